// File: rtl/shift_alu_pkg.sv
// Shared encodings for the shift-then-ALU execute unit.
package shift_alu_pkg;

    // ALUControl encodings (3'b11x selects ZERO)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // shift_op encodings
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Bit positions inside ALUFlags = {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_alu_seq_alu_core.sv
// Combinational ALU stage: one operation on the shifted A against B, with NZCV.
module alu_core
    import shift_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_c;
    logic           w_v;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Operation select; only ADD/SUB produce carry and overflow
    always_comb begin
        result = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                result = w_sum[WIDTH-1:0];
                w_c    = w_sum[WIDTH];
                w_v    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = w_diff[WIDTH-1:0];
                w_c    = w_diff[WIDTH];
                w_v    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_MOV: result = a;
            default: result = '0;
        endcase
    end

    // Pack flags from the selected result
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = w_c;
        flags[FLAG_V] = w_v;
    end

endmodule

// File: rtl/shift_alu_seq.sv
// Multi-cycle execute unit: latch operands, shift A one bit per clock, then one ALU op.
module shift_alu_seq
    import shift_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       shift_op,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_shop;
    logic [SHW-1:0]   r_cnt;
    logic [2:0]       r_ctl;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_alu_res;
    logic [3:0]       w_alu_flags;

    // One-bit step of the latched A; ASR keeps the sign bit, ROR wraps bit 0 to the MSB
    always_comb begin
        w_shifted = r_a;
        case (r_shop)
            SH_LSL:  w_shifted = {r_a[WIDTH-2:0], 1'b0};
            SH_LSR:  w_shifted = {1'b0, r_a[WIDTH-1:1]};
            SH_ASR:  w_shifted = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default: w_shifted = {r_a[0], r_a[WIDTH-1:1]};
        endcase
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a          (r_a),
        .b          (r_b),
        .ALUControl (r_ctl),
        .result     (w_alu_res),
        .flags      (w_alu_flags)
    );

    // Control FSM with registered busy/done/Result/ALUFlags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_shop   <= '0;
            r_cnt    <= '0;
            r_ctl    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            ALUFlags <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_shop <= shift_op;
                        r_cnt  <= shamt;
                        r_ctl  <= ALUControl;
                        busy   <= 1'b1;
                        r_state <= (shamt != '0) ? ST_SHIFT : ST_EXEC;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= w_shifted;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    Result   <= w_alu_res;
                    ALUFlags <= w_alu_flags;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
